// File: rtl/square_pkg.sv
// Shared definitions for the square-root reconstruction and extraction blocks:
// the FSM state encoding and the default root width.
package square_pkg;

    localparam int SQ_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : square_pkg

// File: rtl/square_reconstructor.sv
// Rebuilds a radicand from a square-root/remainder pair as root*root + remainder,
// using a serial shift-add multiplier that consumes one root bit per cycle.
module square_reconstructor
    import square_pkg::*;
#(
    parameter int WIDTH = SQ_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     root,
    input  logic [WIDTH:0]       remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   radicand,
    output logic                 illegal
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = 2 * WIDTH;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic [RW-1:0]      acc_q;
    logic [RW-1:0]      acc_d;
    logic               illegal_q;
    logic               out_valid_q;
    int                 stepIdx;

    // Partial product for the current multiplier bit; the step index counts up
    // from zero as the bit counter runs down from WIDTH.
    always_comb begin
        stepIdx = WIDTH - int'(count_q);
        acc_d   = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + (RW'(mcand_q) << stepIdx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q   <= root;
                        mplier_q  <= root;
                        acc_q     <= RW'(remainder);
                        illegal_q <= (remainder > {root, 1'b0});
                        count_q   <= CW'(WIDTH);
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q - CW'(1);
                    // The last bit is being consumed, so the result is final after this edge.
                    if (count_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign radicand  = acc_q;
    assign illegal   = illegal_q;

endmodule : square_reconstructor
